shadow_ret_stack: RTL and testbench

Hardware shadow return-address stack sitting directly downstream of the commit-stage call/ret parser. The parser sends one push event per committed call (JAL/JALR with rd = x1, confirmed by its custom call NOP) and one pop event per committed return (JALR rs1 = x1, rd = x0, confirmed by its custom ret NOP). This block stores return addresses and checks every return target against the top entry. It flags mismatch, underflow and overflow as a registered violation that the commit logic turns into an exception.

---
 rtl/shadow_ret_stack.sv | 146 ++++++++++++++
 tb/tb_shadow_ret_stack.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/shadow_ret_stack.sv
// rtl/shadow_ret_stack.sv - shadow return-address stack checking committed returns against pushed calls
// Optional wrap-on-overflow behaviour is selected by SHADOW_STACK_WRAP_EN.
module shadow_ret_stack #(
  parameter int DEPTH = 16,
  parameter int XLEN  = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic                     clear_i,
  input  logic                     call_valid_i,
  input  logic [XLEN-1:0]          call_ret_addr_i,
  input  logic                     ret_valid_i,
  input  logic [XLEN-1:0]          ret_target_i,
  output logic                     violation_o,
  output logic [1:0]               cause_o,
  output logic [XLEN-1:0]          expected_o,
  output logic [$clog2(DEPTH):0]   depth_o,
  output logic                     sticky_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] CAUSE_MISMATCH  = 2'b01;
  localparam logic [1:0] CAUSE_UNDERFLOW = 2'b10;
  localparam logic [1:0] CAUSE_OVERFLOW  = 2'b11;

  logic [XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]   sp, sp_n, sp_m1;
  logic [CW-1:0]   cnt, cnt_n;
  logic            viol_n, sticky_n;
  logic [1:0]      cause_n;
  logic [XLEN-1:0] expected_n, top;
  logic            wr_en;
  logic [AW-1:0]   wr_idx;
  logic            uf_flag;

`ifdef SHADOW_STACK_WRAP_EN
  logic wrapped, wrapped_n;
  assign uf_flag = ~wrapped;
`else
  assign uf_flag = 1'b1;
`endif

  assign sp_m1 = sp - AW'(1);
  assign top   = mem[sp_m1];

  always_comb begin
    sp_n       = sp;
    cnt_n      = cnt;
    viol_n     = 1'b0;
    cause_n    = cause_o;
    expected_n = expected_o;
    sticky_n   = sticky_o;
    wr_en      = 1'b0;
    wr_idx     = sp;
`ifdef SHADOW_STACK_WRAP_EN
    wrapped_n  = wrapped;
`endif
    if (clear_i) begin
      sp_n     = '0;
      cnt_n    = '0;
      sticky_n = 1'b0;
`ifdef SHADOW_STACK_WRAP_EN
      wrapped_n = 1'b0;
`endif
    end else if (en_i) begin
      if (ret_valid_i && cnt != '0) begin
        if (top != ret_target_i) begin
          viol_n     = 1'b1;
          cause_n    = CAUSE_MISMATCH;
          expected_n = top;
        end
        if (call_valid_i) begin
          // Pop then push lands in the same slot: replace the top in place.
          wr_en  = 1'b1;
          wr_idx = sp_m1;
        end else begin
          sp_n  = sp_m1;
          cnt_n = cnt - CW'(1);
        end
      end else if (ret_valid_i) begin
        if (uf_flag) begin
          viol_n     = 1'b1;
          cause_n    = CAUSE_UNDERFLOW;
          expected_n = '0;
        end
        if (call_valid_i) begin
          wr_en = 1'b1;
          sp_n  = sp + AW'(1);
          cnt_n = CW'(1);
        end
      end else if (call_valid_i) begin
        if (cnt != CW'(DEPTH)) begin
          wr_en = 1'b1;
          sp_n  = sp + AW'(1);
          cnt_n = cnt + CW'(1);
        end else begin
`ifdef SHADOW_STACK_WRAP_EN
          // Full stack: sp already points at the oldest entry.
          wr_en     = 1'b1;
          sp_n      = sp + AW'(1);
          wrapped_n = 1'b1;
`else
          viol_n     = 1'b1;
          cause_n    = CAUSE_OVERFLOW;
          expected_n = '0;
`endif
        end
      end
      sticky_n = sticky_o | viol_n;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sp          <= '0;
      cnt         <= '0;
      violation_o <= 1'b0;
      cause_o     <= 2'b00;
      expected_o  <= '0;
      sticky_o    <= 1'b0;
`ifdef SHADOW_STACK_WRAP_EN
      wrapped     <= 1'b0;
`endif
    end else begin
      sp          <= sp_n;
      cnt         <= cnt_n;
      violation_o <= viol_n;
      cause_o     <= cause_n;
      expected_o  <= expected_n;
      sticky_o    <= sticky_n;
`ifdef SHADOW_STACK_WRAP_EN
      wrapped     <= wrapped_n;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_idx] <= call_ret_addr_i;
  end

  assign depth_o = cnt;

endmodule

// File: tb/tb_shadow_ret_stack.sv
// tb/tb_shadow_ret_stack.sv - directed self-checking bench for shadow_ret_stack
module tb_shadow_ret_stack;
  localparam int DEPTH = 4;
  localparam int XLEN  = 64;

  logic            clk_i = 1'b0;
  logic            rst_n = 1'b0;
  logic            en_i = 1'b1;
  logic            clear_i = 1'b0;
  logic            call_valid_i = 1'b0;
  logic [XLEN-1:0] call_ret_addr_i = '0;
  logic            ret_valid_i = 1'b0;
  logic [XLEN-1:0] ret_target_i = '0;
  logic            violation_o;
  logic [1:0]      cause_o;
  logic [XLEN-1:0] expected_o;
  logic [$clog2(DEPTH):0] depth_o;
  logic            sticky_o;

  int tests = 0;
  int fails = 0;

  shadow_ret_stack #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .en_i(en_i), .clear_i(clear_i),
    .call_valid_i(call_valid_i), .call_ret_addr_i(call_ret_addr_i),
    .ret_valid_i(ret_valid_i), .ret_target_i(ret_target_i),
    .violation_o(violation_o), .cause_o(cause_o), .expected_o(expected_o),
    .depth_o(depth_o), .sticky_o(sticky_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic cv, input logic [63:0] ca, input logic rv,
                      input logic [63:0] rt, input logic clr);
    call_valid_i    = cv;
    call_ret_addr_i = ca;
    ret_valid_i     = rv;
    ret_target_i    = rt;
    clear_i         = clr;
    @(posedge clk_i);
    #1;
    call_valid_i = 1'b0;
    ret_valid_i  = 1'b0;
    clear_i      = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [1:0] c,
                         input logic [63:0] e, input int d, input logic s);
    chk({tag, ".viol"},   64'(violation_o), 64'(v));
    chk({tag, ".cause"},  64'(cause_o),     64'(c));
    chk({tag, ".exp"},    expected_o,       e);
    chk({tag, ".depth"},  64'(depth_o),     64'(d));
    chk({tag, ".sticky"}, 64'(sticky_o),    64'(s));
  endtask

  initial begin
    #2;
    chk_all("reset", 0, 2'b00, 0, 0, 0);
    @(posedge clk_i); #1;
    rst_n = 1'b1;

    // Balanced calls and returns
    step(1, 64'h1000, 0, 0, 0); chk("c1.depth", 64'(depth_o), 1);
    step(1, 64'h2000, 0, 0, 0); chk("c2.depth", 64'(depth_o), 2);
    step(1, 64'h3000, 0, 0, 0); chk("c3.depth", 64'(depth_o), 3);
    step(0, 0, 1, 64'h3000, 0); chk_all("r1", 0, 2'b00, 0, 2, 0);
    step(0, 0, 1, 64'h2000, 0); chk_all("r2", 0, 2'b00, 0, 1, 0);
    step(0, 0, 1, 64'h1000, 0); chk_all("r3", 0, 2'b00, 0, 0, 0);

    // Mismatch: entry still popped, cause held after the pulse
    step(1, 64'h1000, 0, 0, 0);
    step(0, 0, 1, 64'h1004, 0); chk_all("mis", 1, 2'b01, 64'h1000, 0, 1);
    step(0, 0, 0, 0, 0);        chk_all("mis_hold", 0, 2'b01, 64'h1000, 0, 1);

    // Underflow, then clear
    step(0, 0, 1, 64'h40, 0);   chk_all("uf", 1, 2'b10, 0, 0, 1);
    step(1, 64'h77, 0, 0, 1);   chk_all("clr", 0, 2'b10, 0, 0, 0);

    // DEPTH+1 calls
    for (int i = 0; i < DEPTH; i++) step(1, 64'h100 + 64'(i), 0, 0, 0);
    chk("full.depth", 64'(depth_o), DEPTH);
    step(1, 64'h100 + 64'(DEPTH), 0, 0, 0);
`ifdef SHADOW_STACK_WRAP_EN
    chk_all("ovf", 0, 2'b10, 0, DEPTH, 0);
    for (int i = DEPTH; i > 0; i--) begin
      step(0, 0, 1, 64'h100 + 64'(i), 0);
      chk_all("wpop", 0, 2'b10, 0, i - 1, 0);
    end
    step(0, 0, 1, 64'h55, 0);   chk_all("wuf", 0, 2'b10, 0, 0, 0);
`else
    chk_all("ovf", 1, 2'b11, 0, DEPTH, 1);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      step(0, 0, 1, 64'h100 + 64'(i), 0);
      chk_all("spop", 0, 2'b11, 0, i, 1);
    end
    step(0, 0, 1, 64'h55, 0);   chk_all("suf", 1, 2'b10, 0, 0, 1);
`endif
    step(0, 0, 0, 0, 1);        chk("clr2.sticky", 64'(sticky_o), 0);

    // Same-cycle ret+call replaces the top
    step(1, 64'h1000, 0, 0, 0);
    step(1, 64'h5000, 1, 64'h1000, 0); chk_all("rc", 0, 2'b10, 0, 1, 0);
    step(0, 0, 1, 64'h5000, 0);        chk_all("rc_pop", 0, 2'b10, 0, 0, 0);

    // Same-cycle ret+call on empty: underflow flagged, push still happens
    step(1, 64'h6000, 1, 64'h9, 0);    chk_all("rc_uf", 1, 2'b10, 0, 1, 1);
    step(0, 0, 1, 64'h6000, 0);        chk_all("rc_uf_pop", 0, 2'b10, 0, 0, 1);

    // Same-cycle ret+call on a full stack: no overflow, mismatch against old top
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(1, 64'h200 + 64'(i), 0, 0, 0);
    step(1, 64'h300, 1, 64'h1, 0);
    chk_all("rc_full", 1, 2'b01, 64'h200 + 64'(DEPTH - 1), DEPTH, 1);
    step(0, 0, 1, 64'h300, 0);         chk_all("rc_full_pop", 0, 2'b01, 64'h200 + 64'(DEPTH - 1), DEPTH - 1, 1);

    // Checker disabled
    step(0, 0, 0, 0, 1);
    en_i = 1'b0;
    step(1, 64'hA, 0, 0, 0);
    step(0, 0, 1, 64'hB, 0);           chk_all("dis", 0, 2'b01, 64'h200 + 64'(DEPTH - 1), 0, 0);
    en_i = 1'b1;

    // Asynchronous reset mid-sequence
    step(1, 64'h10, 0, 0, 0);
    step(1, 64'h20, 0, 0, 0);
    step(0, 0, 1, 64'h99, 0);          chk_all("pre_rst", 1, 2'b01, 64'h20, 1, 1);
    #2 rst_n = 1'b0;
    #1;                                 chk_all("async_rst", 0, 2'b00, 0, 0, 0);
    #1 rst_n = 1'b1;
    step(0, 0, 1, 64'h10, 0);          chk_all("post_rst_uf", 1, 2'b10, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
